// File: rtl/display_scan_scheduler_if.sv
`default_nettype none
// display_scan_scheduler_if: scan controls, count inputs and display pins of the scan scheduler.
// Revision 1.0
interface display_scan_scheduler_if;
  logic       freeze;
  logic [7:0] digit_en;
  logic [7:0] press_count;
  logic [7:0] hold_count;
  logic [7:0] release_count;
  logic [6:0] segments;
  logic [7:0] anodos;
  logic       frame_done;

  modport master (
    output freeze, digit_en, press_count, hold_count, release_count,
    input  segments, anodos, frame_done
  );

  modport slave (
    input  freeze, digit_en, press_count, hold_count, release_count,
    output segments, anodos, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/display_scan_scheduler.sv
`default_nettype none
// display_scan_scheduler: single-clock 8-digit seven-segment scanner with per-frame snapshots.
// Revision 1.0
module display_scan_scheduler #(
  parameter int TICK_DIV   = 100000,
  parameter int GAP_CYCLES = 1000
) (
  input wire clock,
  input wire reset,
  display_scan_scheduler_if.slave bus
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GAP_END   = TW'(GAP_CYCLES);

  typedef enum logic [1:0] {
    LATCH = 2'd0,
    GAP   = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_nxt;
  logic [2:0]    digit_idx;
  logic [2:0]    idx_nxt;
  logic          tick_wrap;
  logic          load_snap;
  logic [7:0]    snap_p;
  logic [7:0]    snap_h;
  logic [7:0]    snap_r;
  logic [3:0]    nibble;
  logic          has_value;
  logic [7:0]    anodos_d;
  logic [6:0]    segments_d;
  logic          frame_done_d;
  logic [7:0]    anodos_q;
  logic [6:0]    segments_q;
  logic          frame_done_q;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  always_comb begin
    tick_wrap = (tick_cnt == TICK_LAST);
    tick_nxt  = tick_wrap ? '0 : tick_cnt + TW'(1);
    idx_nxt   = tick_wrap ? digit_idx + 3'd1 : digit_idx;
  end

  // State tracks the tick phase so SHOW coincides exactly with tick_cnt >= GAP_CYCLES.
  always_comb begin
    state_nxt = state;
    load_snap = 1'b0;
    case (state)
      LATCH: begin
        load_snap = ~bus.freeze;
        state_nxt = (tick_nxt >= GAP_END) ? SHOW : GAP;
      end
      GAP: begin
        if (tick_nxt == GAP_END) begin
          state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (tick_wrap) begin
          if (digit_idx == 3'd7) begin
            state_nxt = LATCH;
          end else begin
            state_nxt = (GAP_END == '0) ? SHOW : GAP;
          end
        end
      end
      default: state_nxt = LATCH;
    endcase
  end

  always_comb begin
    nibble    = 4'h0;
    has_value = 1'b1;
    case (digit_idx)
      3'd7:    nibble = snap_p[7:4];
      3'd6:    nibble = snap_p[3:0];
      3'd5:    nibble = snap_h[7:4];
      3'd4:    nibble = snap_h[3:0];
      3'd3:    nibble = snap_r[7:4];
      3'd2:    nibble = snap_r[3:0];
      default: has_value = 1'b0;
    endcase
  end

  always_comb begin
    anodos_d     = 8'hFF;
    segments_d   = 7'h7F;
    frame_done_d = tick_wrap && (digit_idx == 3'd7);
    if (state == SHOW && has_value) begin
      segments_d = hex_to_seg(nibble);
      if (bus.digit_en[digit_idx]) begin
        anodos_d = ~(8'd1 << digit_idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= LATCH;
      tick_cnt  <= '0;
      digit_idx <= 3'd0;
    end else begin
      state     <= state_nxt;
      tick_cnt  <= tick_nxt;
      digit_idx <= idx_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap_p <= 8'h00;
      snap_h <= 8'h00;
      snap_r <= 8'h00;
    end else if (load_snap) begin
      snap_p <= bus.press_count;
      snap_h <= bus.hold_count;
      snap_r <= bus.release_count;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      anodos_q     <= 8'hFF;
      segments_q   <= 7'h7F;
      frame_done_q <= 1'b0;
    end else begin
      anodos_q     <= anodos_d;
      segments_q   <= segments_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.anodos     = anodos_q;
  assign bus.segments   = segments_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_scheduler.sv
`default_nettype none
// tb_display_scan_scheduler: scoreboard bench; stimulus queues expected digits, a monitor pops them.
// Revision 1.0
module tb_display_scan_scheduler;
  localparam int TICK_DIV   = 8;
  localparam int GAP_CYCLES = 2;
  localparam int ON_CYCLES  = TICK_DIV - GAP_CYCLES;
  localparam int FRAME      = 8 * TICK_DIV;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  display_scan_scheduler_if bus ();

  display_scan_scheduler #(
    .TICK_DIV  (TICK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [14:0] exp_q[$];
  logic [7:0]  model_p  = 8'h00;
  logic [7:0]  model_h  = 8'h00;
  logic [7:0]  model_r  = 8'h00;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b0000001;  4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;  4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;  4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;  4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;  4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;  4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;  default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives inputs for the frame about to be latched and queues what that frame must show.
  task automatic frame(input logic [7:0] p, input logic [7:0] h, input logic [7:0] r,
                       input logic [7:0] en, input logic frz);
    logic [7:0] v;
    logic [7:0] an;
    logic [3:0] nib;
    bus.press_count   = p;
    bus.hold_count    = h;
    bus.release_count = r;
    bus.digit_en      = en;
    bus.freeze        = frz;
    if (!frz) begin
      model_p = p;
      model_h = h;
      model_r = r;
    end
    for (int i = 2; i < 8; i++) begin
      if (en[i]) begin
        v     = (i >= 6) ? model_p : (i >= 4) ? model_h : model_r;
        nib   = i[0] ? v[7:4] : v[3:0];
        an    = 8'hFF;
        an[i] = 1'b0;
        exp_q.push_back({an, seg_of(nib)});
      end
    end
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.frame_done !== 1'b1 && n < 4 * FRAME);
    check("frame_done_arrives", bus.frame_done, 1'b1);
  endtask

  task automatic wait_an(input logic [7:0] an);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.anodos !== an && n < 4 * FRAME);
    check("anode_reached", bus.anodos, an);
  endtask

  logic [7:0]  prev_an  = 8'hFF;
  int          off_run  = 0;
  int          on_run   = 0;
  int          since_fd = 0;
  logic [14:0] e;

  always @(negedge clock) begin
    if (!reset) begin
      prev_an  = 8'hFF;
      off_run  = 0;
      on_run   = 0;
      since_fd = 0;
    end else begin
      check("one_anode_max", ($countones(~bus.anodos) <= 1), 1'b1);
      since_fd++;
      if (bus.frame_done) begin
        check("frame_period", since_fd, FRAME);
        since_fd = 0;
      end
      if (bus.anodos == 8'hFF) begin
        if (prev_an != 8'hFF) check("on_length", on_run, ON_CYCLES);
        off_run++;
        on_run = 0;
      end else begin
        if (prev_an == 8'hFF) begin
          check("gap_length", off_run % TICK_DIV, GAP_CYCLES);
          if (exp_q.size() == 0) begin
            check("unexpected_digit", bus.anodos, 8'hFF);
          end else begin
            e = exp_q.pop_front();
            check("digit_anode", bus.anodos, e[14:7]);
            check("digit_segments", bus.segments, e[6:0]);
          end
        end else begin
          check("anode_steady", bus.anodos, prev_an);
        end
        on_run++;
        off_run = 0;
      end
      prev_an = bus.anodos;
    end
  end

  initial begin
    bus.freeze        = 1'b0;
    bus.digit_en      = 8'hFF;
    bus.press_count   = 8'h00;
    bus.hold_count    = 8'h00;
    bus.release_count = 8'h00;
    #2 reset = 1'b0;
    #1;
    check("reset_segments", bus.segments, 7'h7F);
    check("reset_anodos", bus.anodos, 8'hFF);
    check("reset_frame_done", bus.frame_done, 1'b0);

    frame(8'h3A, 8'hF0, 8'h81, 8'hFF, 1'b0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;

    wait_frame(); frame(8'h3A, 8'hF0, 8'h81, 8'hFF, 1'b0);
    wait_frame(); frame(8'h67, 8'hDE, 8'hB9, 8'hFF, 1'b0);

    // Mid-frame input change must not reach the display until the next latch.
    wait_frame(); frame(8'h12, 8'hF0, 8'h81, 8'hFF, 1'b0);
    wait_an(8'hF7);
    bus.press_count = 8'h34;
    wait_frame(); frame(8'h34, 8'hF0, 8'h81, 8'hFF, 1'b0);

    wait_frame(); frame(8'h55, 8'h55, 8'h55, 8'hFF, 1'b0);
    wait_frame(); frame(8'hAA, 8'hAA, 8'hAA, 8'hFF, 1'b1);
    wait_frame(); frame(8'hAA, 8'hAA, 8'hAA, 8'hFF, 1'b1);
    wait_an(8'hF7);
    bus.freeze = 1'b0;
    wait_an(8'hDF);
    bus.freeze = 1'b1;
    wait_frame(); frame(8'hAA, 8'hAA, 8'hAA, 8'hFF, 1'b1);
    wait_frame(); frame(8'hAA, 8'hAA, 8'hAA, 8'hFF, 1'b0);

    wait_frame(); frame(8'hC4, 8'h9E, 8'hD2, 8'b1010_0000, 1'b0);
    wait_frame(); frame(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    wait_frame(); frame(8'h3A, 8'hF0, 8'h81, 8'hFF, 1'b0);
    wait_an(8'hEF);
    #2 reset = 1'b0;
    #1;
    check("async_reset_anodos", bus.anodos, 8'hFF);
    check("async_reset_segments", bus.segments, 7'h7F);
    check("async_reset_frame_done", bus.frame_done, 1'b0);
    exp_q.delete();
    model_p = 8'h00;
    model_h = 8'h00;
    model_r = 8'h00;
    frame(8'h77, 8'h77, 8'h77, 8'hFF, 1'b1);
    repeat (3) @(negedge clock);
    #1 reset = 1'b1;

    wait_frame(); frame(8'h81, 8'h3A, 8'hF0, 8'hFF, 1'b0);
    wait_frame();
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/display_scan_scheduler.md
# display_scan_scheduler

Sequences the 8-digit seven-segment display for the press/hold/release counter datapath. It time-multiplexes three 8-bit counter values onto the shared anode/segment bus and snapshots them once per frame, so every frame shows one consistent set of counts. It inserts a blanking gap between digits to suppress ghosting and pulses `frame_done` at each frame boundary. It replaces the separate clock divider and display driver pair with a single-clock block with no derived clocks.

## Interface
- `TICK_DIV`, default 100000: `clock` cycles per digit slot, including the gap; legal range 4..2^20.
- `GAP_CYCLES`, default 1000: cycles at the start of each slot with all anodes off; must be < `TICK_DIV`.
- `clock`, input, 1: system clock, 100 MHz.
- `reset`, input, 1: asynchronous, active-low reset.
- `freeze`, input, 1: high means keep the current snapshot at frame boundaries.
- `digit_en`, input, 8: per-digit enable. Bit i gates AN_i; a 0 blanks that digit.
- `press_count`, input, 8: shown on AN7 (high nibble) and AN6 (low nibble).
- `hold_count`, input, 8: shown on AN5 and AN4.
- `release_count`, input, 8: shown on AN3 and AN2.
- `segments`, output, 7: {CA..CG}, active-low, registered.
- `anodos`, output, 8: {AN7..AN0}, active-low, registered.
- `frame_done`, output, 1: one-cycle pulse when a frame completes.

## Operation
- **Counters**
  - `tick_cnt` counts 0..`TICK_DIV`-1 and wraps to 0.
  - `digit_idx` is 3 bits. It increments when `tick_cnt` wraps and wraps from 7 to 0.
- **FSM states:** `LATCH`, `GAP`, `SHOW`.
  - `LATCH` (1 cycle). Entered out of reset and whenever `digit_idx` wraps 7→0.
    - If `freeze`=0, copy the three count inputs into `snap_p`, `snap_h`, `snap_r`.
    - Go to `GAP`.
    - `LATCH` occupies cycle 0 of slot 0; the gap count includes it.
  - `GAP`: active while `tick_cnt` < `GAP_CYCLES`.
    - Drive `anodos`=8'hFF and `segments`=7'h7F.
    - Go to `SHOW` when `tick_cnt` = `GAP_CYCLES`.
  - `SHOW`: active while `tick_cnt` ≥ `GAP_CYCLES`.
    - Drive `anodos` = ~(1<<`digit_idx`), gated: force the bit to 1 if `digit_en[digit_idx]`=0.
    - Drive `segments` with the decoded nibble for the current digit.
    - When `tick_cnt` wraps: go to `LATCH` if `digit_idx` was 7, otherwise go to `GAP`.
- **Nibble select**
  - idx 7/6: `snap_p[7:4]` / `snap_p[3:0]`.
  - idx 5/4: `snap_h[7:4]` / `snap_h[3:0]`.
  - idx 3/2: `snap_r[7:4]` / `snap_r[3:0]`.
  - idx 1/0: no value; anode stays off and `segments`=7'h7F regardless of `digit_en`.
- **Hex decode (active-low {CA..CG}):**
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- **Boundary conditions**
  - `freeze` is sampled only in `LATCH`. Toggling it mid-frame has no effect until the next frame.
  - Inputs that change mid-frame are not displayed until the next `LATCH`. This is the required behaviour, not a bug.
  - All-zero `digit_en`: the scan and `frame_done` continue; `anodos` stays 8'hFF.
  - `reset` asserted mid-slot: outputs take their reset values immediately (asynchronous). After release, scanning restarts at `LATCH`, idx 0.

## Timing
- **Reset values:**
  - `segments`=7'h7F, `anodos`=8'hFF, `frame_done`=0.
  - `tick_cnt`=0, `digit_idx`=0, all snapshots = 0.
  - State = `LATCH`.
- All outputs are registered. Each output reflects the state and counters of the previous cycle, giving a 1-cycle latency from a state change to the pins.
- Frame length is 8×`TICK_DIV` cycles. Snapshot-to-display latency is `GAP_CYCLES`+1 cycles for digit 0 and up to 8×`TICK_DIV` for digit 7.
- `frame_done` is high for exactly one cycle: the cycle in which `tick_cnt` wraps with `digit_idx`=7.
- The first `LATCH` after reset release occurs on the first rising edge of `clock` with `reset`=1.
- Anodes never overlap: at most one bit of `anodos` is 0 in any cycle. Every anode change is preceded by ≥`GAP_CYCLES` cycles of 8'hFF.

## Test plan
- **Basic scan.** `TICK_DIV`=8, `GAP_CYCLES`=2, `digit_en`=8'hFF, counts 8'h3A/8'hF0/8'h81, `freeze`=0.
  - AN7 shows 0000110 ("3"), AN6 shows 0001000 ("A").
  - AN5 shows 0111000 ("F"), AN4 shows 0000001 ("0").
  - AN3 shows 0000000 ("8"), AN2 shows 1001111 ("1").
  - AN1/AN0 stay off.
  - `frame_done` pulses every 64 cycles.
- **Gap and overlap.** Same configuration.
  - `anodos`=8'hFF for exactly 2 cycles at the start of each slot.
  - Assert on every cycle that popcount(~`anodos`) ≤ 1.
- **Snapshot consistency.** Change `press_count` from 8'h12 to 8'h34 mid-frame, while idx=3.
  - The remainder of the current frame still shows "1","2" on AN7/AN6.
  - The next frame shows "3","4".
- **Freeze.** Latch 8'h55, set `freeze`=1, change the inputs to 8'hAA for 3 frames.
  - The display stays "5","5".
  - Release `freeze`; the next frame shows "A","A".
- **Digit enable.** Set `digit_en`=8'b1010_0000.
  - Only AN7 and AN5 are ever driven low.
  - `frame_done` cadence is unchanged.
- **Asynchronous reset mid-slot.** Drop `reset` low mid-`SHOW` at idx 4.
  - In the same cycle, with no clock edge needed: `anodos`=8'hFF, `segments`=7'h7F, `frame_done`=0.
  - After release, the scan restarts with `LATCH` and idx 0.
  - The snapshot is 0, so the first frame shows "0" on every enabled digit if the first latch is forced with `freeze`=1.
